// File: rtl/adc_conv_scheduler_if.sv
// Bundle between the conversion scheduler, its requesters and the shared MCP3201 core.
// The scheduler side uses the master modport; the requester/ADC side uses slave.
interface adc_conv_scheduler_if #(
    parameter int NREQ = 4
);
    // Handshake: REQ[i] is a level held until VALID[i] or ERR. GNT is one-hot
    // for the whole conversion. LATCH_ADC is a one-cycle start pulse.
    // Completion is the rising edge of CS_ADC, with VALUE_ADC stable by then.
    // VALID/ERR are one-cycle strobes, and VALUE holds the last delivered result.
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] GNT;
    logic            LATCH_ADC;
    logic            CS_ADC;
    logic [11:0]     VALUE_ADC;
    logic [11:0]     VALUE;
    logic [NREQ-1:0] VALID;
    logic            ERR;
    logic            BUSY;

    modport master (
        input  REQ, CS_ADC, VALUE_ADC,
        output GNT, LATCH_ADC, VALUE, VALID, ERR, BUSY
    );

    modport slave (
        output REQ, CS_ADC, VALUE_ADC,
        input  GNT, LATCH_ADC, VALUE, VALID, ERR, BUSY
    );
endinterface

// File: rtl/adc_conv_scheduler.sv
// Round-robin arbiter sharing one MCP3201 core between NREQ requesters.
// A conversion completes on the rising edge of CS_ADC and aborts after TIMEOUT cycles.
module adc_conv_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023,
    parameter int MIN_GAP = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    adc_conv_scheduler_if.master bus,
    output logic [2:0]           dbg_state
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(MIN_GAP + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_DELIVER   = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;

    logic [2:0]      state;
    logic [PW-1:0]   ptr;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   gap_cnt;
    logic            cs_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] valid_q;
    logic            latch_q;
    logic            err_q;
    logic            busy_q;
    logic [11:0]     value_q;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic [PW-1:0]   cand_idx;
    int              cand;
    logic [TW-1:0]   timer_nxt;
    logic            timed_out;
    logic            cs_rise;

    // First requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(ptr) + k) % NREQ;
            cand_idx = PW'(cand);
            if (!win_found && bus.REQ[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        win_onehot[win_idx] = win_found;
    end

    always_comb begin
        timed_out = (timer == TW'(TIMEOUT));
        timer_nxt = timed_out ? timer : timer + 1'b1;
        cs_rise   = bus.CS_ADC & ~cs_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            ptr     <= '0;
            timer   <= '0;
            gap_cnt <= '0;
            cs_q    <= 1'b1;
            gnt_q   <= '0;
            valid_q <= '0;
            latch_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            value_q <= '0;
        end else begin
            cs_q    <= bus.CS_ADC;
            latch_q <= 1'b0;
            valid_q <= '0;
            err_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt_q   <= win_onehot;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                        ptr     <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    // The first WAIT_LOW cycle already counts as cycle 1.
                    timer <= TW'(1);
                    state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    timer <= timer_nxt;
                    if (timed_out) begin
                        err_q   <= 1'b1;
                        gnt_q   <= '0;
                        gap_cnt <= GW'(MIN_GAP);
                        state   <= S_GAP;
                    end else if (!bus.CS_ADC) begin
                        state <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    timer <= timer_nxt;
                    // A completion edge wins over a timeout landing in the same cycle.
                    if (cs_rise) begin
                        value_q <= bus.VALUE_ADC;
                        valid_q <= gnt_q;
                        gnt_q   <= '0;
                        state   <= S_DELIVER;
                    end else if (timed_out) begin
                        err_q   <= 1'b1;
                        gnt_q   <= '0;
                        gap_cnt <= GW'(MIN_GAP);
                        state   <= S_GAP;
                    end
                end
                S_DELIVER: begin
                    gap_cnt <= GW'(MIN_GAP);
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt <= GW'(1)) begin
                        gap_cnt <= '0;
                        busy_q  <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.GNT       = gnt_q;
    assign bus.LATCH_ADC = latch_q;
    assign bus.VALUE     = value_q;
    assign bus.VALID     = valid_q;
    assign bus.ERR       = err_q;
    assign bus.BUSY      = busy_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler with a behavioural MCP3201 chip-select model.
module tb_adc_conv_scheduler;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
    localparam int MIN_GAP = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] dbg_state;

    adc_conv_scheduler_if #(.NREQ(NREQ)) bus ();

    adc_conv_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .MIN_GAP(MIN_GAP)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int err_cnt = 0;
    int valid_cnt = 0;
    int last_done = 0;
    bit have_last = 0;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (bus.ERR) err_cnt++;
        if (bus.VALID != '0) valid_cnt++;
    end

    // ---------------- ADC model ----------------
    bit          adc_stuck = 1'b0;
    int          adc_low_len = 3;
    logic [11:0] adc_data = '0;
    int          adc_cnt = 0;

    // CS drops in the LATCH cycle, stays low adc_low_len cycles, rises with data.
    initial begin
        bus.CS_ADC    = 1'b1;
        bus.VALUE_ADC = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    bus.CS_ADC    = 1'b1;
                    bus.VALUE_ADC = adc_data;
                end
            end else if (bus.LATCH_ADC && !adc_stuck) begin
                bus.CS_ADC = 1'b0;
                adc_cnt    = adc_low_len;
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no %s within 60 cycles", name, what);
    endtask

    task automatic wait_latch(input string name, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            if (bus.LATCH_ADC) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        if (!ok) expire(name, "LATCH_ADC");
    endtask

    task automatic wait_done(input string name, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            if (bus.VALID != '0 || bus.ERR) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        if (!ok) expire(name, "VALID/ERR");
    endtask

    task automatic do_conv(input string name, input logic [3:0] req,
                           input logic [11:0] data, input logic [3:0] exp_gnt);
        bit ok;
        int lat;
        int dt;
        bus.REQ     = req;
        adc_data    = data;
        adc_stuck   = 1'b0;
        adc_low_len = 3;
        wait_latch(name, ok, lat);
        if (!ok) return;
        check({name, " gnt"}, 32'(bus.GNT), 32'(exp_gnt));
        check({name, " busy"}, 32'(bus.BUSY), 32'd1);
        if (have_last) check({name, " gap"}, 32'(lat - last_done >= MIN_GAP + 2), 32'd1);
        tick();
        check({name, " latch_one_cycle"}, 32'(bus.LATCH_ADC), 32'd0);
        wait_done(name, ok, dt);
        if (!ok) return;
        check({name, " valid"}, 32'(bus.VALID), 32'(exp_gnt));
        check({name, " value"}, 32'(bus.VALUE), 32'(data));
        check({name, " gnt_clear"}, 32'(bus.GNT), 32'd0);
        check({name, " err"}, 32'(bus.ERR), 32'd0);
        last_done = dt;
        have_last = 1'b1;
        tick();
        check({name, " valid_one_cycle"}, 32'(bus.VALID), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  req;
        logic [11:0] data;
        logic [3:0]  gnt;
    } vec_t;

    vec_t vecs[15];

    initial begin
        bit          ok;
        int          lat;
        int          et;
        int          e0;
        int          v0;
        logic [11:0] held;

        // round-robin from ptr=0, fairness with a skip, late REQ[1], single requester
        vecs[0]  = '{4'b1111, 12'h101, 4'b0001};
        vecs[1]  = '{4'b1111, 12'h202, 4'b0010};
        vecs[2]  = '{4'b1111, 12'h303, 4'b0100};
        vecs[3]  = '{4'b1111, 12'h404, 4'b1000};
        vecs[4]  = '{4'b1111, 12'h505, 4'b0001};
        vecs[5]  = '{4'b1111, 12'h606, 4'b0010};
        vecs[6]  = '{4'b1111, 12'h707, 4'b0100};
        vecs[7]  = '{4'b1111, 12'h808, 4'b1000};
        vecs[8]  = '{4'b0101, 12'h0F1, 4'b0001};
        vecs[9]  = '{4'b0101, 12'h0F2, 4'b0100};
        vecs[10] = '{4'b0101, 12'h0F3, 4'b0001};
        vecs[11] = '{4'b0101, 12'h0F4, 4'b0100};
        vecs[12] = '{4'b0101, 12'h0F5, 4'b0001};
        vecs[13] = '{4'b0111, 12'h0F6, 4'b0010};
        vecs[14] = '{4'b0001, 12'hA5C, 4'b0001};

        bus.REQ = '0;
        RST_N   = 1'b0;
        tick();
        tick();
        check("reset gnt", 32'(bus.GNT), 32'd0);
        check("reset latch", 32'(bus.LATCH_ADC), 32'd0);
        check("reset valid", 32'(bus.VALID), 32'd0);
        check("reset err", 32'(bus.ERR), 32'd0);
        check("reset busy", 32'(bus.BUSY), 32'd0);
        check("reset value", 32'(bus.VALUE), 32'd0);
        RST_N = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            do_conv($sformatf("vec%0d", i), vecs[i].req, vecs[i].data, vecs[i].gnt);
        end
        check("table err_count", 32'(err_cnt), 32'd0);
        check("table valid_count", 32'(valid_cnt), 32'd15);

        // timeout: CS never drops, ERR after TIMEOUT+1 cycles from the LATCH cycle
        e0 = err_cnt;
        v0 = valid_cnt;
        held = 12'hA5C;
        adc_stuck = 1'b1;
        bus.REQ = 4'b0010;
        wait_latch("timeout", ok, lat);
        if (ok) begin
            check("timeout gnt", 32'(bus.GNT), 32'b0010);
            wait_done("timeout", ok, et);
            if (ok) begin
                check("timeout err", 32'(bus.ERR), 32'd1);
                check("timeout delay", 32'(et - lat), 32'(TIMEOUT + 1));
                check("timeout valid", 32'(bus.VALID), 32'd0);
                check("timeout value", 32'(bus.VALUE), 32'(held));
                check("timeout gnt_clear", 32'(bus.GNT), 32'd0);
                tick();
                check("timeout err_one_cycle", 32'(bus.ERR), 32'd0);
            end
        end
        check("timeout err_count", 32'(err_cnt - e0), 32'd1);
        check("timeout no_valid", 32'(valid_cnt - v0), 32'd0);
        have_last = 1'b0;
        do_conv("after_timeout", 4'b1100, 12'h5A3, 4'b0100);

        // reset while waiting for CS to rise
        adc_low_len = 10;
        bus.REQ = 4'b0010;
        wait_latch("midreset", ok, lat);
        tick();
        tick();
        tick();
        check("midreset busy_before", 32'(bus.BUSY), 32'd1);
        RST_N = 1'b0;
        bus.REQ = '0;
        tick();
        RST_N = 1'b1;
        check("midreset gnt", 32'(bus.GNT), 32'd0);
        check("midreset latch", 32'(bus.LATCH_ADC), 32'd0);
        check("midreset valid", 32'(bus.VALID), 32'd0);
        check("midreset err", 32'(bus.ERR), 32'd0);
        check("midreset busy", 32'(bus.BUSY), 32'd0);
        check("midreset value", 32'(bus.VALUE), 32'd0);
        for (int i = 0; i < 15; i++) tick();
        have_last = 1'b0;
        do_conv("post_reset", 4'b0010, 12'h3C7, 4'b0010);

        // requester drops REQ one cycle after its grant
        adc_low_len = 3;
        adc_data = 12'h777;
        bus.REQ = 4'b1000;
        wait_latch("req_drop", ok, lat);
        if (ok) begin
            check("req_drop gnt", 32'(bus.GNT), 32'b1000);
            tick();
            bus.REQ = '0;
            wait_done("req_drop", ok, et);
            if (ok) begin
                check("req_drop valid", 32'(bus.VALID), 32'b1000);
                check("req_drop value", 32'(bus.VALUE), 32'h777);
            end
        end
        for (int i = 0; i < MIN_GAP + 4; i++) tick();

        // CS rises in the same cycle the timer reaches TIMEOUT
        e0 = err_cnt;
        adc_low_len = 15;
        adc_data = 12'hBEE;
        bus.REQ = 4'b0001;
        wait_latch("edge_vs_timeout", ok, lat);
        if (ok) begin
            wait_done("edge_vs_timeout", ok, et);
            if (ok) begin
                check("edge_vs_timeout valid", 32'(bus.VALID), 32'b0001);
                check("edge_vs_timeout err", 32'(bus.ERR), 32'd0);
                check("edge_vs_timeout value", 32'(bus.VALUE), 32'hBEE);
                check("edge_vs_timeout delay", 32'(et - lat), 32'd16);
            end
        end
        bus.REQ = '0;
        for (int i = 0; i < 4; i++) tick();
        check("edge_vs_timeout err_count", 32'(err_cnt - e0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
